// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arbStateT;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gntSelT;

  localparam int DEFAULT_MAX_DM_STREAK = 4;

endpackage

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Counts back-to-back data grants taken while a fetch waits; raises
// ifOverride once the streak reaches its limit so fetch wins the next IDLE.
module arb_streak_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = DEFAULT_MAX_DM_STREAK
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   idle,
  input  logic   ifReq,
  input  logic   gntValid,
  input  gntSelT gntSel,
  output logic   ifOverride
);

  localparam int CW = $clog2(MAX_DM_STREAK + 1);

  logic [CW-1:0] streak;

  assign ifOverride = (streak >= CW'(MAX_DM_STREAK));

  // Only IDLE cycles matter: busy cycles neither grant nor let fetch give up.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (idle) begin
      if (!ifReq || (gntValid && gntSel == GNT_IF)) begin
        streak <= '0;
      end else if (gntValid && gntSel == GNT_DM && !ifOverride) begin
        streak <= streak + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the
// load/store stage; registers the winning command and returns data to it.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_DM_STREAK = DEFAULT_MAX_DM_STREAK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall_fe,
  output logic            stall_me,
  output arbStateT        dbgState
);

  arbStateT state;
  gntSelT   gntSel;
  logic     idle;
  logic     ifOverride;
  logic     dmWins;
  logic     ifWins;
  logic     gntValid;

  // Data has priority unless a waiting fetch has already sat out a full streak.
  assign idle     = (state == IDLE);
  assign dmWins   = dm_req && !(if_req && ifOverride);
  assign ifWins   = if_req && !dmWins;
  assign gntValid = idle && (dmWins || ifWins);
  assign gntSel   = dmWins ? GNT_DM : GNT_IF;

  assign if_gnt   = idle && ifWins;
  assign dm_gnt   = idle && dmWins;
  assign stall_fe = if_req && !if_rvalid;
  assign stall_me = dm_req && !dm_rvalid;
  assign dbgState = state;

  arb_streak_ctr #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) uStreak (
    .clk       (clk),
    .reset     (reset),
    .idle      (idle),
    .ifReq     (if_req),
    .gntValid  (gntValid),
    .gntSel    (gntSel),
    .ifOverride(ifOverride)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (gntValid) begin
            mem_req <= 1'b1;
            if (gntSel == GNT_DM) begin
              state     <= BUSY_DM;
              mem_we    <= dm_we;
              mem_be    <= dm_be;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              state     <= BUSY_IF;
              mem_we    <= 1'b0;
              mem_be    <= '1;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
            state     <= IDLE;
          end
        end
        BUSY_DM: begin
          // Stores also pulse dm_rvalid; the captured data is meaningless then.
          if (mem_ack) begin
            mem_req   <= 1'b0;
            dm_rdata  <= mem_rdata;
            dm_rvalid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
